// File: rtl/countdown_pkg.sv
// Shared types and field layout for the MM:SS countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  localparam logic [2:0] TENS_MAX = 3'd5;
  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam int TENS_W = 3;
  localparam int ONES_W = 4;

  localparam int SO_LSB = 0;
  localparam int ST_LSB = 4;
  localparam int MO_LSB = 7;
  localparam int MT_LSB = 11;

  function automatic logic [13:0] clamp_val(
    input logic [13:0] v
  );
    logic [2:0] mt;
    logic [3:0] mo;
    logic [2:0] st;
    logic [3:0] so;
    mt = v[MT_LSB +: TENS_W];
    mo = v[MO_LSB +: ONES_W];
    st = v[ST_LSB +: TENS_W];
    so = v[SO_LSB +: ONES_W];
    if (mt > TENS_MAX) mt = TENS_MAX;
    if (mo > ONES_MAX) mo = ONES_MAX;
    if (st > TENS_MAX) st = TENS_MAX;
    if (so > ONES_MAX) so = ONES_MAX;
    return {mt, mo, st, so};
  endfunction

endpackage

// File: rtl/countdown_timer_down_digit.sv
// One decrementing BCD digit with load clamp and borrow-out.
module down_digit #(
  parameter int W   = 4,
  parameter int MAX = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         dec,
  output logic [W-1:0] q,
  output logic         borrow
);

  localparam logic [W-1:0] MAXV = W'(MAX);

  assign borrow = dec & (q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= (d > MAXV) ? MAXV : d;
    end else if (dec) begin
      q <= (q == '0) ? MAXV : q - 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer built from a chain of down_digit instances.
// Optional auto-reload on expiry: define COUNTDOWN_RELOAD_EN.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [13:0] load_val,
  input  logic        start,
  input  logic        stop,
  output logic [13:0] q,
  output logic        running,
  output logic        zero,
  output logic        done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic          done_q;

  logic          do_load;
  logic          tick;
  logic          expire;
  logic          reload_fire;
  logic          dig_ld;
  logic [13:0]   dig_d;
  logic [13:0]   reload_val;

  logic [2:0] mt;
  logic [3:0] mo;
  logic [2:0] st;
  logic [3:0] so;
  logic b_so;
  logic b_st;
  logic b_mo;
  logic b_mt;

  assign q       = {mt, mo, st, so};
  assign zero    = (q == 14'd0);
  assign running = (state_q == RUN);
  assign done    = done_q;

  assign do_load = load && (state_q != RUN);
  assign tick    = (state_q == RUN) && !stop && (pre_q == PMAX);
  assign expire  = tick && (q == 14'd1);

`ifdef COUNTDOWN_RELOAD_EN
  logic [13:0] reload_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload_q <= '0;
    end else if (do_load) begin
      reload_q <= clamp_val(load_val);
    end
  end

  assign reload_val  = reload_q;
  assign reload_fire = expire && (reload_q != 14'd0);
`else
  assign reload_val  = '0;
  assign reload_fire = 1'b0;
`endif

  assign dig_ld = do_load || reload_fire;
  assign dig_d  = do_load ? load_val : reload_val;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!load && !stop && start && !zero)
          state_d = RUN;
      end
      RUN: begin
        if (stop)
          state_d = PAUSE;
        else if (expire && !reload_fire)
          state_d = DONE;
      end
      PAUSE: begin
        if (load)
          state_d = IDLE;
        else if (!stop && start)
          state_d = RUN;
      end
      DONE: begin
        if (load)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Prescaler restarts from zero whenever a fresh run begins.
  always_comb begin
    pre_d = pre_q;
    if (do_load)
      pre_d = '0;
    else if (state_q != PAUSE && state_q != RUN
             && state_d == RUN)
      pre_d = '0;
    else if (state_q == RUN && !stop)
      pre_d = (pre_q == PMAX) ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      done_q  <= expire;
    end
  end

  down_digit #(.W(ONES_W), .MAX(int'(ONES_MAX))) u_so (
    .clk    (clk),
    .reset  (reset),
    .load   (dig_ld),
    .d      (dig_d[SO_LSB +: ONES_W]),
    .dec    (tick),
    .q      (so),
    .borrow (b_so)
  );

  down_digit #(.W(TENS_W), .MAX(int'(TENS_MAX))) u_st (
    .clk    (clk),
    .reset  (reset),
    .load   (dig_ld),
    .d      (dig_d[ST_LSB +: TENS_W]),
    .dec    (b_so),
    .q      (st),
    .borrow (b_st)
  );

  down_digit #(.W(ONES_W), .MAX(int'(ONES_MAX))) u_mo (
    .clk    (clk),
    .reset  (reset),
    .load   (dig_ld),
    .d      (dig_d[MO_LSB +: ONES_W]),
    .dec    (b_st),
    .q      (mo),
    .borrow (b_mo)
  );

  down_digit #(.W(TENS_W), .MAX(int'(TENS_MAX))) u_mt (
    .clk    (clk),
    .reset  (reset),
    .load   (dig_ld),
    .d      (dig_d[MT_LSB +: TENS_W]),
    .dec    (b_mo),
    .q      (mt),
    .borrow (b_mt)
  );

  logic unused;
  assign unused = b_mt;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (TICK_DIV=4).
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [13:0] load_val = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [13:0] q;
  logic        running;
  logic        zero;
  logic        done;

  int total = 0;
  int bad = 0;

  countdown_timer #(.TICK_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .q        (q),
    .running  (running),
    .zero     (zero),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] mmss(
    input int mt, input int mo,
    input int st, input int so
  );
    return {mt[2:0], mo[3:0], st[2:0], so[3:0]};
  endfunction

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [13:0] v);
    load = 1'b1;
    load_val = v;
    step(1);
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_run", 32'(running), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    #10 reset = 1'b1;
    step(1);

    do_load(mmss(0, 0, 0, 3));
    chk("ld3_q", 32'(q), 32'(mmss(0, 0, 0, 3)));
    chk("ld3_run", 32'(running), 32'd0);
    pulse_start();
    chk("st_run", 32'(running), 32'd1);
    step(3);
    chk("k3_q", 32'(q), 32'(mmss(0, 0, 0, 3)));
    step(1);
    chk("k4_q", 32'(q), 32'(mmss(0, 0, 0, 2)));
    step(4);
    chk("k8_q", 32'(q), 32'(mmss(0, 0, 0, 1)));
    step(3);
    chk("k11_done", 32'(done), 32'd0);
    step(1);
    chk("k12_done", 32'(done), 32'd1);
`ifdef COUNTDOWN_RELOAD_EN
    chk("k12_q", 32'(q), 32'(mmss(0, 0, 0, 3)));
    chk("k12_run", 32'(running), 32'd1);
    chk("k12_zero", 32'(zero), 32'd0);
    step(1);
    chk("k13_done", 32'(done), 32'd0);
    step(3);
    chk("rl_q", 32'(q), 32'(mmss(0, 0, 0, 2)));
    pulse_stop();
    chk("rl_stop", 32'(running), 32'd0);
`else
    chk("k12_q", 32'(q), 32'd0);
    chk("k12_run", 32'(running), 32'd0);
    chk("k12_zero", 32'(zero), 32'd1);
    step(1);
    chk("k13_done", 32'(done), 32'd0);
    pulse_start();
    chk("dn_start", 32'(running), 32'd0);
    step(6);
    chk("dn_q", 32'(q), 32'd0);
    chk("dn_done", 32'(done), 32'd0);
`endif

    do_load(mmss(1, 0, 0, 0));
    chk("ld10_q", 32'(q), 32'(mmss(1, 0, 0, 0)));
    pulse_start();
    step(4);
    chk("b10_q", 32'(q), 32'(mmss(0, 9, 5, 9)));
    pulse_stop();
    chk("b10_stop", 32'(running), 32'd0);
    do_load(mmss(0, 1, 0, 0));
    chk("ld01_run", 32'(running), 32'd0);
    pulse_start();
    step(4);
    chk("b01_q", 32'(q), 32'(mmss(0, 0, 5, 9)));
    pulse_stop();

    do_load(mmss(0, 0, 1, 0));
    load = 1'b1;
    load_val = mmss(0, 0, 1, 0);
    pulse_start();
    load = 1'b0;
    chk("ld_pri", 32'(running), 32'd0);
    pulse_start();
    step(2);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("ps_run", 32'(running), 32'd0);
    step(10);
    chk("ps_hold", 32'(q), 32'(mmss(0, 0, 1, 0)));
    pulse_start();
    chk("rs_run", 32'(running), 32'd1);
    chk("rs_q0", 32'(q), 32'(mmss(0, 0, 1, 0)));
    step(1);
    chk("rs_q1", 32'(q), 32'(mmss(0, 0, 1, 0)));
    step(1);
    chk("rs_q2", 32'(q), 32'(mmss(0, 0, 0, 9)));
    load = 1'b1;
    load_val = mmss(0, 0, 0, 1);
    step(1);
    load = 1'b0;
    chk("run_ld", 32'(q), 32'(mmss(0, 0, 0, 9)));
    start = 1'b1;
    stop = 1'b1;
    step(1);
    start = 1'b0;
    stop = 1'b0;
    chk("ss_run", 32'(running), 32'd0);
    step(5);
    chk("ss_q", 32'(q), 32'(mmss(0, 0, 0, 9)));

    do_load(14'h3FFF);
    chk("clamp", 32'(q), 32'(mmss(5, 9, 5, 9)));
    do_load(mmss(7, 15, 6, 12));
    chk("clamp2", 32'(q), 32'(mmss(5, 9, 5, 9)));
    do_load(14'h0000);
    chk("z_zero", 32'(zero), 32'd1);
    pulse_start();
    chk("z_run", 32'(running), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("z_done", 32'(done), 32'd0);
    end

    do_load(mmss(0, 0, 0, 5));
    pulse_start();
    step(2);
    chk("mr_run", 32'(running), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mr_q", 32'(q), 32'd0);
    chk("mr_run0", 32'(running), 32'd0);
    chk("mr_zero", 32'(zero), 32'd1);
    chk("mr_done", 32'(done), 32'd0);
    step(1);
    reset = 1'b1;
    step(1);
    chk("mr_idle", 32'(running), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
MM:SS countdown timer, 00:00–59:59, built from decrementing BCD digits with a borrow chain. It is the down-counting counterpart of the team's up-counting clock digits.
- Loaded with a start value, started, paused and resumed by single-cycle strobes.
- Signals expiry with a one-cycle done pulse.
- Sits beside the clock/stopwatch blocks and drives the same 7-segment display path.

Parameters:
TICK_DIV, 4, clk cycles per one-second decrement; legal range ≥1; 1 = decrement every enabled cycle.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; 0 = reset asserted
load  input  1  strobe: capture load_val
load_val  input  14  {min_tens[13:11], min_ones[10:7], sec_tens[6:4], sec_ones[3:0]}
start  input  1  strobe: begin/resume counting
stop  input  1  strobe: pause counting
q  output  14  current value, same packing as load_val
running  output  1  high in RUN state
zero  output  1  high when q == 0
done  output  1  one-cycle pulse on expiry

Behaviour:
- Reset (reset==0, async): state IDLE, q=0, prescaler=0, reload register=0, running=0, done=0, zero=1.
- All outputs registered; zero is decoded combinationally from the registered q.
- Load clamping:
  - tens digits >5 load as 5; ones digits >9 load as 9.
  - Example: load_val 3'd7,4'hF,3'd6,4'hC → 59:59.
- Digit decrement, applied only on a tick:
  - sec_ones: 0→9 with borrow, else −1.
  - sec_tens: decrements only on borrow-in; 0→5 with borrow.
  - min_ones: 0→9 with borrow.
  - min_tens: 0→5.
- Prescaler:
  - Counts 0..TICK_DIV−1 in RUN only; a tick occurs when it equals TICK_DIV−1 and it then wraps to 0.
  - Held in PAUSE; cleared on every load and on IDLE/DONE→RUN.
- State machine (priority within a cycle: load > stop > start):
  - IDLE
    - load → q=clamped load_val; stay IDLE.
    - start with q≠0 → RUN.
    - start with q==0 → stay IDLE, no done.
  - RUN
    - stop → PAUSE (stop wins over a simultaneous start).
    - load → ignored.
    - Tick with q≠00:01 → q decrements.
    - Tick with q==00:01 → q=0, state DONE, done=1 for exactly that one cycle.
  - PAUSE
    - start → RUN; prescaler resumes from its held value.
    - load → q=clamped load_val, prescaler cleared, state IDLE.
    - stop → ignored.
  - DONE
    - q holds 0, zero=1.
    - start → ignored.
    - load → q=clamped load_val, state IDLE.
- Latency:
  - start sampled at edge k → running=1 after edge k.
  - First decrement at edge k+TICK_DIV.
  - A value N seconds expires at edge k+N·TICK_DIV.
- Reset mid-operation: immediate return to reset values, including clearing any pending done pulse.

Optional Feature:
COUNTDOWN_RELOAD_EN
- Defined:
  - A 14-bit reload register captures every clamped load value.
  - On the expiry tick in RUN, q is set to the reload value instead of 0 and the state stays RUN. done still pulses for one cycle; zero does not assert.
  - If the reload value is 0, expiry behaves as without the feature (→ DONE).
- Undefined: no reload register; expiry always → DONE as above.

Decomposition:
- Package countdown_pkg:
  - state_t enum {IDLE, RUN, PAUSE, DONE}.
  - localparams TENS_MAX=3'd5, ONES_MAX=4'd9, TENS_W=3, ONES_W=4.
  - Field-slice localparams for the 14-bit packing.
- Sub-module down_digit #(W, MAX):
  - Inputs: clk, reset, load, d, dec.
  - Outputs: q, borrow (= dec & q==0).
  - Clamps d>MAX to MAX on load.
  - Four instances, chained: borrow of each digit drives dec of the next.

Test Plan:
- Reset: assert reset=0 mid-RUN → q=0, running=0, zero=1, done=0 asynchronously, before the next clk edge.
- Basic expiry: TICK_DIV=4, load 00:03, start at edge k → q=00:02/00:01/00:00 at edges k+4/k+8/k+12; done high only after edge k+12; state DONE; a further start is ignored.
- Borrow chain: load 10:00, run one tick → 09:59; load 01:00, one tick → 00:59.
- Pause/resume: start, stop after 2 clocks, hold 10 clocks (q and prescaler frozen), start → next decrement 2 clocks later; start+stop in the same cycle in RUN → PAUSE.
- Clamp and zero start: load 14'h3FFF → q=59:59; load 0 then start → stays IDLE, done never asserts.
- COUNTDOWN_RELOAD_EN: load 00:02, start, TICK_DIV=1 → sequence 02, 01, 02, 01…; done pulses at each reload; running stays 1.
